// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage : MIPS-style ID stage (register file, forwarding, branch, ID/EX)
// Revision     : 1.0
// ============================================================================
module decode_stage #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dunit_clk_en,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [NB_REG-1:0]  i_inst,
  input  logic [NB_REG-1:0]  i_pcplus4,
  input  logic               i_regWrite_from_WB,
  input  logic [NB_ADDR-1:0] i_WB_addr,
  input  logic [NB_REG-1:0]  i_WB_data,
  input  logic [NB_REG-1:0]  i_ex_result,
  input  logic [NB_REG-1:0]  i_mem_result,
  input  logic [1:0]         i_forwardA,
  input  logic [1:0]         i_forwardB,
  input  logic               i_branch,
  input  logic [1:0]         i_br_mode,
  input  logic [NB_ADDR-1:0] i_dunit_addr,
  output logic [NB_REG-1:0]  o_dunit_reg,
  output logic               o_PCSrc_to_IF,
  output logic [NB_REG-1:0]  o_branch_target,
  output logic [NB_REG-1:0]  o_pc_jsel_to_IF,
  output logic               o_valid,
  output logic [NB_REG-1:0]  o_pcplus8,
  output logic [NB_REG-1:0]  o_imm,
  output logic [NB_REG-1:0]  o_rs_data,
  output logic [NB_REG-1:0]  o_rt_data,
  output logic [5:0]         o_funct,
  output logic [NB_ADDR-1:0] o_rs_addr,
  output logic [NB_ADDR-1:0] o_rt_addr,
  output logic [NB_ADDR-1:0] o_rd_addr
);
  localparam int DEPTH = 2**NB_ADDR;

  logic [NB_REG-1:0]  rf_q [DEPTH];
  logic [NB_REG-1:0]  rf_d [DEPTH];
  logic               wb_we;
  logic [NB_ADDR-1:0] rs_addr, rt_addr, rd_addr;
  logic [NB_REG-1:0]  rs_rf, rt_rf, dbg_rf;
  logic [NB_REG-1:0]  rs_fwd, rt_fwd, imm, target;
  logic               cond;
  logic               unused_inst;

  logic               valid_q, valid_d;
  logic [NB_REG-1:0]  pcplus8_q, pcplus8_d, imm_q, imm_d;
  logic [NB_REG-1:0]  rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [5:0]         funct_q, funct_d;
  logic [NB_ADDR-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;

  assign rs_addr     = NB_ADDR'(i_inst[25:21]);
  assign rt_addr     = NB_ADDR'(i_inst[20:16]);
  assign rd_addr     = NB_ADDR'(i_inst[15:11]);
  assign unused_inst = ^i_inst[31:26];
  assign wb_we       = i_dunit_clk_en & i_regWrite_from_WB & (i_WB_addr != '0);

  // Reads see a same-cycle write-back so WB->ID needs no extra forwarding path.
  always_comb begin
    rs_rf  = (wb_we && i_WB_addr == rs_addr) ? i_WB_data : rf_q[rs_addr];
    rt_rf  = (wb_we && i_WB_addr == rt_addr) ? i_WB_data : rf_q[rt_addr];
    dbg_rf = (wb_we && i_WB_addr == i_dunit_addr) ? i_WB_data : rf_q[i_dunit_addr];
    if (rs_addr == '0)      rs_rf  = '0;
    if (rt_addr == '0)      rt_rf  = '0;
    if (i_dunit_addr == '0) dbg_rf = '0;
  end

  always_comb begin
    case (i_forwardA)
      2'b01:   rs_fwd = i_ex_result;
      2'b10:   rs_fwd = i_mem_result;
      default: rs_fwd = rs_rf;
    endcase
    case (i_forwardB)
      2'b01:   rt_fwd = i_ex_result;
      2'b10:   rt_fwd = i_mem_result;
      default: rt_fwd = rt_rf;
    endcase
  end

  assign imm    = {{(NB_REG-16){i_inst[15]}}, i_inst[15:0]};
  assign target = i_pcplus4 + (imm << 2);

  always_comb begin
    case (i_br_mode)
      2'b00:   cond = (rs_fwd == rt_fwd);
      2'b01:   cond = (rs_fwd != rt_fwd);
      2'b10:   cond = rs_fwd[NB_REG-1] | (rs_fwd == '0);
      default: cond = ~rs_fwd[NB_REG-1] & (rs_fwd != '0);
    endcase
  end

  assign o_PCSrc_to_IF   = i_branch & cond & ~i_stall & ~i_flush;
  assign o_branch_target = target;
  assign o_pc_jsel_to_IF = rs_fwd;
  assign o_dunit_reg     = dbg_rf;

  always_comb begin
    rf_d = rf_q;
    if (wb_we) rf_d[i_WB_addr] = i_WB_data;
  end

  always_comb begin
    valid_d   = valid_q;
    pcplus8_d = pcplus8_q;
    imm_d     = imm_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    funct_d   = funct_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    if (i_dunit_clk_en) begin
      if (i_flush || i_stall) begin
        valid_d   = 1'b0;
        pcplus8_d = '0;
        imm_d     = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        funct_d   = '0;
        rs_addr_d = '0;
        rt_addr_d = '0;
        rd_addr_d = '0;
      end else begin
        valid_d   = 1'b1;
        pcplus8_d = i_pcplus4 + NB_REG'(4);
        imm_d     = imm;
        rs_data_d = rs_fwd;
        rt_data_d = rt_fwd;
        funct_d   = i_inst[5:0];
        rs_addr_d = rs_addr;
        rt_addr_d = rt_addr;
        rd_addr_d = rd_addr;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rf_q      <= '{default: '0};
      valid_q   <= 1'b0;
      pcplus8_q <= '0;
      imm_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      funct_q   <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      rf_q      <= rf_d;
      valid_q   <= valid_d;
      pcplus8_q <= pcplus8_d;
      imm_q     <= imm_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      funct_q   <= funct_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_pcplus8 = pcplus8_q;
  assign o_imm     = imm_q;
  assign o_rs_data = rs_data_q;
  assign o_rt_data = rt_data_q;
  assign o_funct   = funct_q;
  assign o_rs_addr = rs_addr_q;
  assign o_rt_addr = rt_addr_q;
  assign o_rd_addr = rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// tb_decode_stage : table vectors, directed corner sequences and random stimulus
// checked against a behavioural model of the decode stage.
module tb_decode_stage;
  localparam int NB_REG  = 32;
  localparam int NB_ADDR = 5;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, stall, flush, wb_we, branch;
  logic [31:0] inst, pcplus4, wb_data, ex_res, mem_res;
  logic [4:0]  wb_addr, dunit_addr;
  logic [1:0]  fa, fb, br_mode;
  logic [31:0] dunit_reg, br_target, jsel, pcplus8, imm_o, rs_data, rt_data;
  logic        pcsrc, valid;
  logic [5:0]  funct;
  logic [4:0]  rs_a, rt_a, rd_a;

  always #5 clk = ~clk;

  decode_stage #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_dunit_clk_en(clk_en), .i_stall(stall), .i_flush(flush),
    .i_inst(inst), .i_pcplus4(pcplus4), .i_regWrite_from_WB(wb_we), .i_WB_addr(wb_addr),
    .i_WB_data(wb_data), .i_ex_result(ex_res), .i_mem_result(mem_res), .i_forwardA(fa),
    .i_forwardB(fb), .i_branch(branch), .i_br_mode(br_mode), .i_dunit_addr(dunit_addr),
    .o_dunit_reg(dunit_reg), .o_PCSrc_to_IF(pcsrc), .o_branch_target(br_target),
    .o_pc_jsel_to_IF(jsel), .o_valid(valid), .o_pcplus8(pcplus8), .o_imm(imm_o),
    .o_rs_data(rs_data), .o_rt_data(rt_data), .o_funct(funct), .o_rs_addr(rs_a),
    .o_rt_addr(rt_a), .o_rd_addr(rd_a)
  );

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic        e_valid;
  logic [31:0] e_pc8, e_imm, e_rs, e_rt;
  logic [5:0]  e_funct;
  logic [4:0]  e_rsa, e_rta, e_rda;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [1:0]  fa;
    logic [31:0] ex;
    logic [31:0] mem;
    logic [1:0]  mode;
    logic        stall;
    logic        exp_pcsrc;
    logic [31:0] exp_target;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (clk_en && wb_we && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [4:0] a);
    if (sel == 2'b01) return ex_res;
    if (sel == 2'b10) return mem_res;
    return m_read(a);
  endfunction

  function automatic logic [31:0] m_imm();
    int s;
    s = int'($signed(inst[15:0]));
    return 32'(s);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    e_valid = 1'b0; e_pc8 = 0; e_imm = 0; e_rs = 0; e_rt = 0;
    e_funct = 0; e_rsa = 0; e_rta = 0; e_rda = 0;
  endtask

  task automatic check_comb();
    logic [31:0] rs, rt, tgt;
    logic        c;
    rs  = m_fwd(fa, inst[25:21]);
    rt  = m_fwd(fb, inst[20:16]);
    tgt = pcplus4 + m_imm() * 32'd4;
    case (br_mode)
      2'd0: c = (rs == rt);
      2'd1: c = (rs != rt);
      2'd2: c = ($signed(rs) <= 0);
      default: c = ($signed(rs) > 0);
    endcase
    chk("pcsrc", 32'(pcsrc), 32'(branch && c && !stall && !flush));
    chk("branch_target", br_target, tgt);
    chk("pc_jsel", jsel, rs);
    chk("dunit_reg", dunit_reg, m_read(dunit_addr));
  endtask

  task automatic check_regs();
    chk("valid", 32'(valid), 32'(e_valid));
    chk("pcplus8", pcplus8, e_pc8);
    chk("imm", imm_o, e_imm);
    chk("rs_data", rs_data, e_rs);
    chk("rt_data", rt_data, e_rt);
    chk("funct", 32'(funct), 32'(e_funct));
    chk("rs_addr", 32'(rs_a), 32'(e_rsa));
    chk("rt_addr", 32'(rt_a), 32'(e_rta));
    chk("rd_addr", 32'(rd_a), 32'(e_rda));
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_clear();
    end else if (clk_en) begin
      if (flush || stall) begin
        e_valid = 1'b0; e_pc8 = 0; e_imm = 0; e_rs = 0; e_rt = 0;
        e_funct = 0; e_rsa = 0; e_rta = 0; e_rda = 0;
      end else begin
        e_valid = 1'b1;
        e_pc8   = pcplus4 + 32'd4;
        e_imm   = m_imm();
        e_rs    = m_fwd(fa, inst[25:21]);
        e_rt    = m_fwd(fb, inst[20:16]);
        e_funct = inst[5:0];
        e_rsa   = inst[25:21];
        e_rta   = inst[20:16];
        e_rda   = inst[15:11];
      end
      if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
    end
  endtask

  // Inputs are driven at the falling edge; combinational outputs are checked
  // mid-low-phase, registered outputs at the following falling edge.
  task automatic cycle();
    #2;
    check_comb();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle();
    clk_en = 1; stall = 0; flush = 0; wb_we = 0; branch = 0;
    inst = 0; pcplus4 = 0; wb_data = 0; ex_res = 0; mem_res = 0;
    wb_addr = 0; dunit_addr = 0; fa = 0; fb = 0; br_mode = 0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    idle();
    wb_we = 1; wb_addr = a; wb_data = d;
    cycle();
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
    return {6'h04, rs, rt, im};
  endfunction

  initial begin
    idle();
    rst_n = 0;
    m_clear();
    repeat (2) @(negedge clk);
    check_regs();
    chk("reset_dunit", dunit_reg, 32'd0);
    rst_n = 1;

    // Operands: r1=r2=0x10, r3=0x80000000
    wb_write(5'd1, 32'h10);
    wb_write(5'd2, 32'h10);
    wb_write(5'd3, 32'h8000_0000);

    tbl[0] = '{mk(1, 2, 16'hFFFF), 32'h100, 2'b00, 0, 0, 2'd0, 1'b0, 1'b1, 32'h0000_00FC};
    tbl[1] = '{mk(1, 2, 16'hFFFF), 32'h100, 2'b00, 0, 0, 2'd0, 1'b1, 1'b0, 32'h0000_00FC};
    tbl[2] = '{mk(3, 0, 16'h0004), 32'h200, 2'b00, 0, 0, 2'd2, 1'b0, 1'b1, 32'h0000_0210};
    tbl[3] = '{mk(3, 0, 16'h0004), 32'h200, 2'b00, 0, 0, 2'd3, 1'b0, 1'b0, 32'h0000_0210};
    tbl[4] = '{mk(3, 0, 16'h0000), 32'h300, 2'b01, 5, 0, 2'd3, 1'b0, 1'b1, 32'h0000_0300};
    tbl[5] = '{mk(1, 3, 16'h8000), 32'h0002_0000, 2'b00, 0, 0, 2'd1, 1'b0, 1'b1, 32'h0000_0000};
    tbl[6] = '{mk(1, 3, 16'h0001), 32'hFFFF_FFFC, 2'b00, 0, 0, 2'd0, 1'b0, 1'b0, 32'h0000_0000};
    tbl[7] = '{mk(1, 0, 16'h0000), 32'h400, 2'b10, 0, 0, 2'd2, 1'b0, 1'b1, 32'h0000_0400};

    foreach (tbl[i]) begin
      idle();
      inst = tbl[i].inst; pcplus4 = tbl[i].pc4; fa = tbl[i].fa;
      ex_res = tbl[i].ex; mem_res = tbl[i].mem; br_mode = tbl[i].mode;
      stall = tbl[i].stall; branch = 1;
      #1;
      chk($sformatf("tbl%0d_pcsrc", i), 32'(pcsrc), 32'(tbl[i].exp_pcsrc));
      chk($sformatf("tbl%0d_target", i), br_target, tbl[i].exp_target);
      #1;
      @(posedge clk); model_edge(); @(negedge clk); check_regs();
    end

    // Same-cycle WB write bypasses into the read of rs
    idle();
    wb_we = 1; wb_addr = 5; wb_data = 32'h1234_5678; inst = mk(5, 0, 16'h0);
    cycle();
    chk("bypass_rs_data", rs_data, 32'h1234_5678);

    // Writes to r0 are dropped
    idle();
    wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF; dunit_addr = 0;
    cycle();
    chk("r0_read", dunit_reg, 32'd0);

    // Capture, stall bubble, flush bubble
    idle(); inst = mk(5, 1, 16'h1234); pcplus4 = 32'h40;
    cycle();
    chk("pre_stall_valid", 32'(valid), 32'd1);
    stall = 1; cycle();
    chk("stall_valid", 32'(valid), 32'd0);
    chk("stall_rs", rs_data, 32'd0);
    stall = 0; flush = 1; pcplus4 = 32'h80; cycle();
    chk("flush_valid", 32'(valid), 32'd0);
    chk("flush_pc8", pcplus8, 32'd0);

    // Freeze: three disabled cycles with changing inputs and a WB write
    idle(); inst = mk(1, 2, 16'h0055); pcplus4 = 32'h500; cycle();
    clk_en = 0;
    for (int k = 0; k < 3; k++) begin
      inst = $urandom; pcplus4 = $urandom; stall = k[0];
      wb_we = 1; wb_addr = 5'd7; wb_data = 32'hDEAD_0000 + k;
      cycle();
    end
    chk("freeze_pc8", pcplus8, 32'h504);
    chk("freeze_valid", 32'(valid), 32'd1);
    idle(); dunit_addr = 5'd7; #1;
    chk("freeze_no_write", dunit_reg, 32'd0);

    // Asynchronous reset between edges
    @(negedge clk);
    idle(); inst = mk(5, 5, 16'h7777); pcplus4 = 32'h600; cycle();
    chk("pre_reset_valid", 32'(valid), 32'd1);
    #2; rst_n = 0; #1;
    m_clear();
    chk("areset_valid", 32'(valid), 32'd0);
    chk("areset_rs", rs_data, 32'd0);
    chk("areset_imm", imm_o, 32'd0);
    dunit_addr = 5'd5; #1;
    chk("areset_r5", dunit_reg, 32'd0);
    @(negedge clk);
    rst_n = 1;
    idle(); inst = mk(5, 0, 16'h0001); pcplus4 = 32'h700;
    cycle();
    chk("post_reset_valid", 32'(valid), 32'd1);

    // Random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      clk_en = ($urandom_range(0, 7) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      inst = {$urandom} & 32'hFC7F_FFFF;
      pcplus4 = $urandom; wb_data = $urandom; ex_res = $urandom; mem_res = $urandom;
      wb_we = $urandom_range(0, 1);
      wb_addr = ($urandom_range(0, 2) == 0) ? inst[25:21] : 5'($urandom_range(0, 31));
      dunit_addr = 5'($urandom_range(0, 31));
      fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
      branch = $urandom_range(0, 1); br_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ex_res = 32'd0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
